// File: rtl/dma_cmd_scheduler.sv
// dma_cmd_scheduler: round-robin arbiter over NUM_CH DMA requesters that issues one
// read/write command pair at a time, collects both statuses and reports completion
// on the granted channel.
// Optional watchdog: define DMA_SCHED_TIMEOUT_EN to abort stalled transfers after
// TIMEOUT_CYCLES cycles in ISSUE/WAIT (DoneStat 11).

module dma_cmd_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_CH-1:0]          ReqValid,
  output logic [NUM_CH-1:0]          ReqReady,
  input  logic [NUM_CH*ADDR_W-1:0]   ReqSrc,
  input  logic [NUM_CH*ADDR_W-1:0]   ReqDst,
  input  logic [NUM_CH*LEN_W-1:0]    ReqLen,
  output logic                       RdCmdValid,
  input  logic                       RdCmdReady,
  output logic [ADDR_W-1:0]          RdCmdAddr,
  output logic [LEN_W-1:0]           RdCmdLen,
  output logic                       WrCmdValid,
  input  logic                       WrCmdReady,
  output logic [ADDR_W-1:0]          WrCmdAddr,
  output logic [LEN_W-1:0]           WrCmdLen,
  input  logic                       RdStatValid,
  output logic                       RdStatReady,
  input  logic [1:0]                 RdStat,
  input  logic                       WrStatValid,
  output logic                       WrStatReady,
  input  logic [1:0]                 WrStat,
  output logic [NUM_CH-1:0]          DoneValid,
  input  logic [NUM_CH-1:0]          DoneReady,
  output logic [1:0]                 DoneStat,
  output logic                       Busy,
  output logic [$clog2(NUM_CH)-1:0]  GrantId
);

  localparam int unsigned IdW = $clog2(NUM_CH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, grant_q;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [LEN_W-1:0]   len_q;
  logic               rd_cmd_done_q, wr_cmd_done_q;
  logic               rd_stat_got_q, wr_stat_got_q;
  logic [1:0]         rd_stat_q, wr_stat_q;
  logic [1:0]         done_stat_q, done_stat_d;

  logic [IdW-1:0]     sel_id;
  logic               sel_found;
  logic [IdW:0]       rr_idx;
  logic [LEN_W-1:0]   sel_len;
  logic               accept;
  logic               rd_cmd_hs, wr_cmd_hs, rd_stat_hs, wr_stat_hs;
  logic               rd_cmd_now, wr_cmd_now, rd_stat_now, wr_stat_now;
  logic [1:0]         rd_stat_eff, wr_stat_eff;
  logic               timeout, rd_drain, wr_drain, draining;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      rr_idx = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (rr_idx >= (IdW+1)'(NUM_CH)) rr_idx = rr_idx - (IdW+1)'(NUM_CH);
      if (!sel_found && ReqValid[rr_idx[IdW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = rr_idx[IdW-1:0];
      end
    end
  end

  assign sel_len = ReqLen[sel_id*LEN_W +: LEN_W];
  // ARESET gates the grant so nothing is accepted while reset is held
  assign accept  = (state_q == StIdle) && sel_found && !ARESET && !draining;

  assign rd_cmd_hs  = RdCmdValid & RdCmdReady;
  assign wr_cmd_hs  = WrCmdValid & WrCmdReady;
  assign rd_stat_hs = RdStatValid & RdStatReady;
  assign wr_stat_hs = WrStatValid & WrStatReady;

  // "now" views fold in this cycle's handshake so decisions need no extra cycle
  assign rd_cmd_now  = rd_cmd_done_q | rd_cmd_hs;
  assign wr_cmd_now  = wr_cmd_done_q | wr_cmd_hs;
  assign rd_stat_now = rd_stat_got_q | rd_stat_hs;
  assign wr_stat_now = wr_stat_got_q | wr_stat_hs;
  assign rd_stat_eff = rd_stat_got_q ? rd_stat_q : RdStat;
  assign wr_stat_eff = wr_stat_got_q ? wr_stat_q : WrStat;
  assign draining    = rd_drain | wr_drain;

  // Next-state and completion status
  always_comb begin
    state_d     = state_q;
    done_stat_d = done_stat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (sel_len == '0) begin
            state_d     = StDone;
            done_stat_d = 2'b00;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (timeout) begin
          state_d     = StDone;
          done_stat_d = 2'b11;
        end else if (rd_cmd_now && wr_cmd_now) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rd_stat_now && wr_stat_now) begin
          state_d     = StDone;
          done_stat_d = (rd_stat_eff != 2'b00) ? rd_stat_eff : wr_stat_eff;
        end else if (timeout) begin
          state_d     = StDone;
          done_stat_d = 2'b11;
        end
      end
      StDone: begin
        if (DoneReady[grant_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ReqReady    = '0;
    RdCmdValid  = 1'b0;
    WrCmdValid  = 1'b0;
    RdStatReady = 1'b0;
    WrStatReady = 1'b0;
    DoneValid   = '0;
    if (accept) ReqReady[sel_id] = 1'b1;
    unique case (state_q)
      StIdle: begin
        RdStatReady = rd_drain;
        WrStatReady = wr_drain;
      end
      StIssue: begin
        RdCmdValid  = !rd_cmd_done_q;
        WrCmdValid  = !wr_cmd_done_q;
        RdStatReady = 1'b1;
        WrStatReady = 1'b1;
      end
      StWait: begin
        RdStatReady = 1'b1;
        WrStatReady = 1'b1;
      end
      StDone:  DoneValid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign RdCmdAddr = src_q;
  assign RdCmdLen  = len_q;
  assign WrCmdAddr = dst_q;
  assign WrCmdLen  = len_q;
  assign DoneStat  = done_stat_q;
  assign Busy      = (state_q != StIdle);
  assign GrantId   = grant_q;

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latch the granted request and track per-transfer handshake progress
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr_q      <= IdW'(NUM_CH - 1);
      grant_q       <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      rd_cmd_done_q <= 1'b0;
      wr_cmd_done_q <= 1'b0;
      rd_stat_got_q <= 1'b0;
      wr_stat_got_q <= 1'b0;
      rd_stat_q     <= 2'b00;
      wr_stat_q     <= 2'b00;
      done_stat_q   <= 2'b00;
    end else begin
      done_stat_q <= done_stat_d;
      if (accept) begin
        rr_ptr_q      <= sel_id;
        grant_q       <= sel_id;
        src_q         <= ReqSrc[sel_id*ADDR_W +: ADDR_W];
        dst_q         <= ReqDst[sel_id*ADDR_W +: ADDR_W];
        len_q         <= sel_len;
        rd_cmd_done_q <= 1'b0;
        wr_cmd_done_q <= 1'b0;
        rd_stat_got_q <= 1'b0;
        wr_stat_got_q <= 1'b0;
      end else begin
        if (rd_cmd_hs) rd_cmd_done_q <= 1'b1;
        if (wr_cmd_hs) wr_cmd_done_q <= 1'b1;
        if (rd_stat_hs && !rd_stat_got_q) begin
          rd_stat_got_q <= 1'b1;
          rd_stat_q     <= RdStat;
        end
        if (wr_stat_hs && !wr_stat_got_q) begin
          wr_stat_got_q <= 1'b1;
          wr_stat_q     <= WrStat;
        end
      end
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            rd_drain_q, wr_drain_q;
  logic            tmo_fire;

  // IDLE always precedes ISSUE, so clearing there restarts the count per transfer
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                        tmo_cnt_q <= '0;
    else if (state_q == StIdle)                        tmo_cnt_q <= '0;
    else if (state_q == StIssue || state_q == StWait)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout  = (state_q == StIssue || state_q == StWait) &&
                    (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  // Completion in the same cycle as expiry wins over the abort
  assign tmo_fire = timeout && !(state_q == StWait && rd_stat_now && wr_stat_now);

  // Owe a status only for commands that were actually handed over
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_drain_q <= 1'b0;
      wr_drain_q <= 1'b0;
    end else if (tmo_fire) begin
      rd_drain_q <= rd_cmd_now && !rd_stat_now;
      wr_drain_q <= wr_cmd_now && !wr_stat_now;
    end else if (state_q == StIdle) begin
      if (RdStatValid) rd_drain_q <= 1'b0;
      if (WrStatValid) wr_drain_q <= 1'b0;
    end
  end

  assign rd_drain = rd_drain_q;
  assign wr_drain = wr_drain_q;
`else
  logic unused_tmo;

  assign timeout    = 1'b0;
  assign rd_drain   = 1'b0;
  assign wr_drain   = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Directed testbench for dma_cmd_scheduler (NUM_CH 4, ADDR_W 32, LEN_W 16).
// The watchdog scenario is compiled only when DMA_SCHED_TIMEOUT_EN is defined.

module tb_dma_cmd_scheduler;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int LW  = 16;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b0;
  logic [NCH-1:0]    ReqValid = '0;
  logic [NCH-1:0]    ReqReady;
  logic [NCH*AW-1:0] ReqSrc = '0;
  logic [NCH*AW-1:0] ReqDst = '0;
  logic [NCH*LW-1:0] ReqLen = '0;
  logic              RdCmdValid, WrCmdValid;
  logic              RdCmdReady = 1'b0, WrCmdReady = 1'b0;
  logic [AW-1:0]     RdCmdAddr, WrCmdAddr;
  logic [LW-1:0]     RdCmdLen, WrCmdLen;
  logic              RdStatValid = 1'b0, WrStatValid = 1'b0;
  logic              RdStatReady, WrStatReady;
  logic [1:0]        RdStat = 2'b00, WrStat = 2'b00;
  logic [NCH-1:0]    DoneValid;
  logic [NCH-1:0]    DoneReady = '0;
  logic [1:0]        DoneStat;
  logic              Busy;
  logic [1:0]        GrantId;

  int n_vec = 0;
  int n_err = 0;

  dma_cmd_scheduler #(
    .NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqSrc(ReqSrc), .ReqDst(ReqDst), .ReqLen(ReqLen),
    .RdCmdValid(RdCmdValid), .RdCmdReady(RdCmdReady),
    .RdCmdAddr(RdCmdAddr), .RdCmdLen(RdCmdLen),
    .WrCmdValid(WrCmdValid), .WrCmdReady(WrCmdReady),
    .WrCmdAddr(WrCmdAddr), .WrCmdLen(WrCmdLen),
    .RdStatValid(RdStatValid), .RdStatReady(RdStatReady), .RdStat(RdStat),
    .WrStatValid(WrStatValid), .WrStatReady(WrStatReady), .WrStat(WrStat),
    .DoneValid(DoneValid), .DoneReady(DoneReady), .DoneStat(DoneStat),
    .Busy(Busy), .GrantId(GrantId)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len);
    ReqSrc[ch*AW +: AW] = src;
    ReqDst[ch*AW +: AW] = dst;
    ReqLen[ch*LW +: LW] = len;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    ReqValid = '0; DoneReady = '0;
    RdStatValid = 1'b0; WrStatValid = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    ARESET = 1'b1;
    ReqValid = 4'b1111;
    tick();
    n_vec++;
    if (ReqReady !== 4'b0000) begin
      n_err++; $display("FAIL reset_req_ready got=%b want=0000", ReqReady);
    end
    n_vec++;
    if ({Busy, RdCmdValid, WrCmdValid, RdStatReady, WrStatReady} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b want=00000",
                        {Busy, RdCmdValid, WrCmdValid, RdStatReady, WrStatReady});
    end
    n_vec++;
    if ({DoneValid, DoneStat, GrantId} !== 8'h00) begin
      n_err++; $display("FAIL reset_done got=%h want=00", {DoneValid, DoneStat, GrantId});
    end
    tick();
    ReqValid = '0;
    ARESET = 1'b0;
  endtask

  task automatic test_single();
    set_req(1, 32'h1000, 32'h2000, 16'd256);
    RdCmdReady = 1'b1; WrCmdReady = 1'b1;
    RdStat = 2'b00; WrStat = 2'b00; RdStatValid = 1'b1; WrStatValid = 1'b1;
    ReqValid = 4'b0010;
    #1;
    n_vec++;
    if (ReqReady !== 4'b0010) begin
      n_err++; $display("FAIL single_req_ready got=%b want=0010", ReqReady);
    end
    tick();
    ReqValid = '0;
    n_vec++;
    if ({RdCmdValid, WrCmdValid, Busy, GrantId} !== 5'b11101) begin
      n_err++; $display("FAIL single_issue got=%b want=11101",
                        {RdCmdValid, WrCmdValid, Busy, GrantId});
    end
    n_vec++;
    if (RdCmdAddr !== 32'h1000 || RdCmdLen !== 16'd256) begin
      n_err++; $display("FAIL single_rdcmd got=%h/%0d want=1000/256", RdCmdAddr, RdCmdLen);
    end
    n_vec++;
    if (WrCmdAddr !== 32'h2000 || WrCmdLen !== 16'd256) begin
      n_err++; $display("FAIL single_wrcmd got=%h/%0d want=2000/256", WrCmdAddr, WrCmdLen);
    end
    tick();
    n_vec++;
    if ({RdCmdValid, WrCmdValid, DoneValid} !== 6'b0) begin
      n_err++; $display("FAIL single_wait got=%b want=000000",
                        {RdCmdValid, WrCmdValid, DoneValid});
    end
    tick();
    RdStatValid = 1'b0; WrStatValid = 1'b0;
    n_vec++;
    if (DoneValid !== 4'b0010 || DoneStat !== 2'b00) begin
      n_err++; $display("FAIL single_done got=%b/%b want=0010/00", DoneValid, DoneStat);
    end
    DoneReady = 4'b0010;
    tick();
    DoneReady = '0;
    n_vec++;
    if (Busy !== 1'b0 || DoneValid !== 4'b0000) begin
      n_err++; $display("FAIL single_idle got=%b/%b want=0/0000", Busy, DoneValid);
    end
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] exp_oh;
    logic [AW-1:0]  exp_src;
    do_reset();
    for (int c = 0; c < NCH; c++) set_req(c, AW'(32'h100 * (c + 1)), AW'(32'h8000 + c), 16'd16);
    RdCmdReady = 1'b1; WrCmdReady = 1'b1;
    RdStat = 2'b00; WrStat = 2'b00; RdStatValid = 1'b1; WrStatValid = 1'b1;
    DoneReady = 4'b1111;
    ReqValid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_oh  = 4'b0001 << (k % 4);
      exp_src = AW'(32'h100 * ((k % 4) + 1));
      n_vec++;
      if (ReqReady !== exp_oh) begin
        n_err++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, ReqReady, exp_oh);
      end
      tick();
      n_vec++;
      if (GrantId !== 2'(k % 4) || RdCmdAddr !== exp_src) begin
        n_err++; $display("FAIL rr_grant[%0d] got=%0d/%h want=%0d/%h",
                          k, GrantId, RdCmdAddr, k % 4, exp_src);
      end
      tick();
      tick();
      n_vec++;
      if (DoneValid !== exp_oh || ReqReady !== 4'b0000) begin
        n_err++; $display("FAIL rr_done[%0d] got=%b/%b want=%b/0000",
                          k, DoneValid, ReqReady, exp_oh);
      end
      tick();
    end
    ReqValid = '0; DoneReady = '0;
    RdStatValid = 1'b0; WrStatValid = 1'b0;
  endtask

  task automatic test_wr_delay();
    set_req(3, 32'h3000, 32'h4000, 16'd64);
    RdCmdReady = 1'b1; WrCmdReady = 1'b0;
    RdStat = 2'b10; RdStatValid = 1'b1; WrStat = 2'b00; WrStatValid = 1'b0;
    ReqValid = 4'b1000;
    #1;
    n_vec++;
    if (ReqReady !== 4'b1000) begin
      n_err++; $display("FAIL wrdly_ready got=%b want=1000", ReqReady);
    end
    tick();
    ReqValid = '0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (WrCmdValid !== 1'b1 || RdCmdValid !== (i == 0) || WrCmdAddr !== 32'h4000) begin
        n_err++; $display("FAIL wrdly_issue[%0d] got=%b/%b/%h want=1/%b/4000",
                          i, WrCmdValid, RdCmdValid, WrCmdAddr, i == 0);
      end
      tick();
      RdStatValid = 1'b0;
    end
    WrCmdReady = 1'b1; WrStatValid = 1'b1;
    #1;
    n_vec++;
    if (WrCmdValid !== 1'b1 || Busy !== 1'b1) begin
      n_err++; $display("FAIL wrdly_hs got=%b/%b want=1/1", WrCmdValid, Busy);
    end
    tick();
    WrCmdReady = 1'b0; WrStatValid = 1'b0;
    n_vec++;
    if ({WrCmdValid, RdCmdValid, DoneValid} !== 6'b0) begin
      n_err++; $display("FAIL wrdly_wait got=%b want=000000",
                        {WrCmdValid, RdCmdValid, DoneValid});
    end
    tick();
    n_vec++;
    if (DoneValid !== 4'b1000 || DoneStat !== 2'b10) begin
      n_err++; $display("FAIL wrdly_done got=%b/%b want=1000/10", DoneValid, DoneStat);
    end
    DoneReady = 4'b1000;
    tick();
    DoneReady = '0;
  endtask

  task automatic test_zero_len();
    set_req(2, 32'h5000, 32'h6000, 16'd0);
    RdCmdReady = 1'b0; WrCmdReady = 1'b0;
    ReqValid = 4'b0100;
    #1;
    n_vec++;
    if (ReqReady !== 4'b0100) begin
      n_err++; $display("FAIL zlen_ready got=%b want=0100", ReqReady);
    end
    tick();
    n_vec++;
    if (RdCmdValid !== 1'b0 || WrCmdValid !== 1'b0) begin
      n_err++; $display("FAIL zlen_nocmd got=%b/%b want=0/0", RdCmdValid, WrCmdValid);
    end
    n_vec++;
    if (DoneValid !== 4'b0100 || DoneStat !== 2'b00 || GrantId !== 2'd2) begin
      n_err++; $display("FAIL zlen_done got=%b/%b/%0d want=0100/00/2",
                        DoneValid, DoneStat, GrantId);
    end
    DoneReady = 4'b0100;
    tick();
    DoneReady = '0;
    n_vec++;
    if (ReqReady !== 4'b0100) begin
      n_err++; $display("FAIL zlen_backtoback got=%b want=0100", ReqReady);
    end
    ReqValid = '0;
  endtask

  task automatic test_stat_order();
    set_req(0, 32'h7000, 32'h8000, 16'd32);
    RdCmdReady = 1'b1; WrCmdReady = 1'b1;
    ReqValid = 4'b0001;
    #1;
    n_vec++;
    if (ReqReady !== 4'b0001) begin
      n_err++; $display("FAIL order_ready got=%b want=0001", ReqReady);
    end
    tick();
    ReqValid = '0;
    WrStat = 2'b01; WrStatValid = 1'b1; RdStatValid = 1'b0;
    #1;
    n_vec++;
    if (WrStatReady !== 1'b1 || RdCmdValid !== 1'b1) begin
      n_err++; $display("FAIL order_wrstat got=%b/%b want=1/1", WrStatReady, RdCmdValid);
    end
    tick();
    WrStatValid = 1'b0; RdStat = 2'b00; RdStatValid = 1'b1;
    #1;
    n_vec++;
    if (RdStatReady !== 1'b1 || DoneValid !== 4'b0000) begin
      n_err++; $display("FAIL order_wait got=%b/%b want=1/0000", RdStatReady, DoneValid);
    end
    tick();
    RdStatValid = 1'b0;
    DoneReady = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (DoneValid !== 4'b0001 || DoneStat !== 2'b01) begin
        n_err++; $display("FAIL order_hold[%0d] got=%b/%b want=0001/01",
                          i, DoneValid, DoneStat);
      end
      tick();
    end
    DoneReady = 4'b0001;
    tick();
    DoneReady = '0;
    n_vec++;
    if (Busy !== 1'b0 || DoneValid !== 4'b0000) begin
      n_err++; $display("FAIL order_idle got=%b/%b want=0/0000", Busy, DoneValid);
    end
  endtask

  task automatic test_reset_mid();
    set_req(1, 32'h9000, 32'hA000, 16'd8);
    RdCmdReady = 1'b1; WrCmdReady = 1'b1;
    RdStatValid = 1'b0; WrStatValid = 1'b0;
    ReqValid = 4'b0010;
    tick();
    ReqValid = '0;
    tick();
    n_vec++;
    if (Busy !== 1'b1 || RdStatReady !== 1'b1 || GrantId !== 2'd1) begin
      n_err++; $display("FAIL rmid_wait got=%b/%b/%0d want=1/1/1", Busy, RdStatReady, GrantId);
    end
    ARESET = 1'b1;
    ReqValid = 4'b0110;
    #1;
    n_vec++;
    if ({Busy, RdStatReady, WrStatReady, RdCmdValid, WrCmdValid} !== 5'b0) begin
      n_err++; $display("FAIL rmid_ctrl got=%b want=00000",
                        {Busy, RdStatReady, WrStatReady, RdCmdValid, WrCmdValid});
    end
    n_vec++;
    if ({DoneValid, DoneStat, GrantId, ReqReady} !== 12'h000) begin
      n_err++; $display("FAIL rmid_outs got=%h want=000",
                        {DoneValid, DoneStat, GrantId, ReqReady});
    end
    tick();
    tick();
    ARESET = 1'b0;
    #1;
    n_vec++;
    if (DoneValid !== 4'b0000 || ReqReady !== 4'b0010) begin
      n_err++; $display("FAIL rmid_after got=%b/%b want=0000/0010", DoneValid, ReqReady);
    end
    ReqValid = '0;
    tick();
  endtask

`ifdef DMA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    set_req(0, 32'hB000, 32'hC000, 16'd4);
    RdCmdReady = 1'b1; WrCmdReady = 1'b1;
    RdStatValid = 1'b0; WrStatValid = 1'b0;
    ReqValid = 4'b0001;
    #1;
    tick();
    ReqValid = '0;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (DoneValid !== 4'b0000 || Busy !== 1'b1) begin
        n_err++; $display("FAIL tmo_pending[%0d] got=%b/%b want=0000/1", i, DoneValid, Busy);
      end
      tick();
    end
    n_vec++;
    if (DoneValid !== 4'b0001 || DoneStat !== 2'b11) begin
      n_err++; $display("FAIL tmo_done got=%b/%b want=0001/11", DoneValid, DoneStat);
    end
    DoneReady = 4'b0001;
    tick();
    DoneReady = '0;
    ReqValid = 4'b0001;
    #1;
    n_vec++;
    if ({Busy, RdStatReady, WrStatReady, ReqReady} !== 7'b0110000) begin
      n_err++; $display("FAIL tmo_drain got=%b want=0110000",
                        {Busy, RdStatReady, WrStatReady, ReqReady});
    end
    RdStatValid = 1'b1; WrStatValid = 1'b1;
    tick();
    RdStatValid = 1'b0; WrStatValid = 1'b0;
    #1;
    n_vec++;
    if ({RdStatReady, WrStatReady, ReqReady} !== 6'b000001) begin
      n_err++; $display("FAIL tmo_drained got=%b want=000001",
                        {RdStatReady, WrStatReady, ReqReady});
    end
    ReqValid = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wr_delay();
    test_zero_len();
    test_stat_order();
    test_reset_mid();
`ifdef DMA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/dma_cmd_scheduler.md
DMA_CMD_SCHEDULER -- requirements
Module: dma_cmd_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter LEN_W, default 16, transfer length width in bytes.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit (used only under REQ-031).
REQ-005 ACLK  in  1  single clock; all logic rising-edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 ReqValid  in  NUM_CH  per-channel transfer request.
REQ-008 ReqReady  out  NUM_CH  per-channel request accept, one-hot or zero.
REQ-009 ReqSrc / ReqDst  in  NUM_CH*ADDR_W each  source/destination address; channel i occupies slice i.
REQ-010 ReqLen  in  NUM_CH*LEN_W  byte count per channel.
REQ-011 RdCmdValid/RdCmdReady  out/in  1  read command handshake; RdCmdAddr out ADDR_W; RdCmdLen out LEN_W.
REQ-012 WrCmdValid/WrCmdReady  out/in  1  write command handshake; WrCmdAddr out ADDR_W; WrCmdLen out LEN_W.
REQ-013 RdStatValid/RdStatReady  in/out  1; RdStat  in  2  read status (00 OK, else error).
REQ-014 WrStatValid/WrStatReady  in/out  1; WrStat  in  2  write status.
REQ-015 DoneValid  out  NUM_CH, DoneReady  in  NUM_CH, DoneStat  out  2  per-channel completion.
REQ-016 Busy  out  1  high in any state except IDLE; GrantId  out  $clog2(NUM_CH)  channel currently served.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transfer outstanding at a time.
REQ-018 IDLE: if any ReqValid, select by round-robin starting at (last grant + 1) mod NUM_CH, assert ReqReady for that channel only in the same cycle (combinational from registered pointer), latch src/dst/len and GrantId, go to ISSUE next cycle.
REQ-019 Round-robin pointer SHALL update only on an accepted request; a lone requester is granted back-to-back.
REQ-020 ReqLen of 0 SHALL be accepted and completed directly (IDLE->DONE, DoneStat 00) without issuing commands.
REQ-021 ISSUE: assert RdCmdValid and WrCmdValid together the cycle after acceptance; each drops independently on its own handshake; payloads stable while valid.
REQ-022 Leave ISSUE only when both commands handshaken (same or different cycles), then WAIT.
REQ-023 RdStatReady and WrStatReady SHALL be high in ISSUE and WAIT only; each status captured once; status arriving before its partner's command handshake SHALL still be captured.
REQ-024 WAIT->DONE the cycle after both statuses captured; DoneStat = RdStat if RdStat != 00, else WrStat.
REQ-025 DONE: assert DoneValid[GrantId] with DoneStat stable; on DoneReady[GrantId] go to IDLE; DoneReady on other bits ignored.
REQ-026 Minimum request-to-DoneValid latency SHALL be 3 cycles with all readies/statuses immediate.
REQ-027 ReqValid changes on non-granted channels SHALL not affect an in-flight transfer.

Reset
REQ-028 ARESET assertion SHALL immediately force: state IDLE, ReqReady 0, RdCmdValid 0, WrCmdValid 0, RdStatReady 0, WrStatReady 0, DoneValid 0, DoneStat 00, Busy 0, GrantId 0, round-robin pointer to NUM_CH-1 (channel 0 first).
REQ-029 Reset mid-transfer SHALL abandon the transfer with no DoneValid; the datapath is reset concurrently by system.
REQ-030 First arbitration SHALL occur no earlier than the first rising edge after ARESET deasserts.

Configuration
REQ-031 Macro DMA_SCHED_TIMEOUT_EN defined: counter cleared on entering ISSUE, increments each cycle in ISSUE/WAIT; on reaching TIMEOUT_CYCLES, drop all cmd valids, go to DONE with DoneStat 11; late statuses for that transfer SHALL be accepted and discarded in IDLE until both are absorbed.
REQ-032 Macro undefined: no counter, no timeout path; RdStatReady/WrStatReady behave per REQ-023 only.

Verification
REQ-033 Single channel 1 request (src 0x1000, dst 0x2000, len 256), immediate readies and status 00 -> RdCmd/WrCmd fields match, DoneValid[1] 3 cycles after accept, DoneStat 00.
REQ-034 All 4 channels ReqValid held continuously, 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-035 WrCmdReady delayed 5 cycles, RdStat 10 and WrStat 00 -> remain ISSUE until WrCmd handshake; DoneStat 10.
REQ-036 WrStatValid arriving before RdStatValid, DoneReady delayed 4 cycles -> DoneValid held with stable DoneStat until ready; return to IDLE next cycle.
REQ-037 ReqLen 0 on channel 2 -> no RdCmdValid/WrCmdValid; DoneValid[2], DoneStat 00.
REQ-038 ARESET pulsed during WAIT -> all outputs per REQ-028 in the same cycle; with DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES 16, statuses withheld -> DoneStat 11 after 16 cycles.
